// File: rtl/ula_cmd_seq.sv
// Byte-stream command sequencer wrapping the combinational ULA: 3-byte command in, 2-byte result out.
// Optional divide-by-zero detection enabled by defining ULA_DIVZERO_CHK_EN.
module ula_cmd_seq #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        err,
    output logic        busy,
    output logic [7:0]  ula_a,
    output logic [7:0]  ula_b,
    output logic [3:0]  ula_sel,
    input  logic [15:0] ula_s
);

    localparam int unsigned CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

    typedef enum logic [2:0] {
        RX_SEL = 3'd0,
        RX_A   = 3'd1,
        RX_B   = 3'd2,
        EXEC   = 3'd3,
        CAP    = 3'd4,
        TX_HI  = 3'd5,
        TX_LO  = 3'd6
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [15:0]   res;
    logic [15:0]   cap_val;
    logic          in_xfer;

    assign in_xfer = in_valid && in_ready;

    // Value captured from the ULA, substituted on a detected divide by zero
`ifdef ULA_DIVZERO_CHK_EN
    logic divzero;
    always_comb begin
        divzero = (ula_sel == 4'b0011) && (ula_b == 8'h00);
        cap_val = divzero ? 16'hFFFF : ula_s;
    end
`else
    always_comb begin
        cap_val = ula_s;
    end
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RX_SEL;
            cnt       <= '0;
            res       <= 16'h0000;
            ula_a     <= 8'h00;
            ula_b     <= 8'h00;
            ula_sel   <= 4'h0;
            in_ready  <= 1'b0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
`ifdef ULA_DIVZERO_CHK_EN
            err       <= 1'b0;
`endif
        end else begin
            case (state)
                RX_SEL: begin
                    in_ready <= 1'b1;
                    if (in_xfer) begin
                        ula_sel <= in_data[3:0];
                        busy    <= 1'b1;
                        state   <= RX_A;
`ifdef ULA_DIVZERO_CHK_EN
                        err     <= 1'b0;
`endif
                    end
                end
                RX_A: begin
                    if (in_xfer) begin
                        ula_a <= in_data;
                        state <= RX_B;
                    end
                end
                RX_B: begin
                    if (in_xfer) begin
                        ula_b    <= in_data;
                        cnt      <= CW'(EXEC_CYCLES - 1);
                        in_ready <= 1'b0;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    // Operands are held stable; the count covers the ULA settle time
                    if (cnt == '0) begin
                        state <= CAP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                CAP: begin
                    res       <= cap_val;
                    out_data  <= cap_val[15:8];
                    out_valid <= 1'b1;
                    out_last  <= 1'b0;
                    state     <= TX_HI;
`ifdef ULA_DIVZERO_CHK_EN
                    err       <= divzero;
`endif
                end
                TX_HI: begin
                    if (out_ready) begin
                        out_data <= res[7:0];
                        out_last <= 1'b1;
                        state    <= TX_LO;
                    end else begin
                        out_data <= res[15:8];
                    end
                end
                TX_LO: begin
                    // Last byte handed off: reopen the input for the next frame
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        out_data  <= 8'h00;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= RX_SEL;
                    end
                end
                default: begin
                    state    <= RX_SEL;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ula_cmd_seq.sv
// Self-checking bench for ula_cmd_seq: directed frame table plus reset corner sequences.
module tb_ula_cmd_seq;

    localparam int unsigned EXEC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        err;
    logic        busy;
    logic [7:0]  ula_a;
    logic [7:0]  ula_b;
    logic [3:0]  ula_sel;
    logic [15:0] ula_s;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [7:0] sel;
        logic [7:0] a;
        logic [7:0] b;
        int         gap;
        int         stall;
        logic [7:0] hi;
        logic [7:0] lo;
        logic       e;
    } vec_t;

    ula_cmd_seq #(.EXEC_CYCLES(EXEC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .err       (err),
        .busy      (busy),
        .ula_a     (ula_a),
        .ula_b     (ula_b),
        .ula_sel   (ula_sel),
        .ula_s     (ula_s)
    );

    always #5 clk = ~clk;

    // Behavioural ULA; divide by zero returns a recognisable raw pattern
    always_comb begin
        case (ula_sel)
            4'd0:    ula_s = {8'h00, ula_a} + {8'h00, ula_b};
            4'd1:    ula_s = {8'h00, ula_a} - {8'h00, ula_b};
            4'd2:    ula_s = {8'h00, ula_a} * {8'h00, ula_b};
            4'd3:    ula_s = (ula_b == 8'h00) ? 16'hDEAD : ({8'h00, ula_a} / {8'h00, ula_b});
            default: ula_s = 16'h0000;
        endcase
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_accept", 16'(in_ready), 16'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic recv(input string name, input logic [7:0] exp, input logic last, input logic e);
        out_ready = 1'b1;
        @(negedge clk);
        chk({name, "_valid"}, 16'(out_valid), 16'h1);
        chk({name, "_data"}, 16'(out_data), 16'(exp));
        chk({name, "_last"}, 16'(out_last), 16'(last));
        chk({name, "_err"}, 16'(err), 16'(e));
        chk({name, "_in_ready"}, 16'(in_ready), 16'h0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_frame(input vec_t v);
        int  cnt = 0;
        logic saw_ready = 1'b0;
        logic bad_hold = 1'b0;
        send_byte(v.sel);
        chk("busy_after_sel", 16'(busy), 16'h1);
        repeat (v.gap) @(posedge clk);
        #1;
        send_byte(v.a);
        repeat (v.gap) @(posedge clk);
        #1;
        send_byte(v.b);
        do begin
            @(posedge clk);
            #1;
            cnt++;
            if (!out_valid && in_ready) saw_ready = 1'b1;
        end while (!out_valid && cnt < 50);
        chk("latency", 16'(cnt), 16'(EXEC + 1));
        chk("in_ready_exec", 16'(saw_ready), 16'h0);
        for (int i = 0; i < v.stall; i++) begin
            if (out_valid !== 1'b1 || out_data !== v.hi || in_ready !== 1'b0) bad_hold = 1'b1;
            @(posedge clk);
            #1;
        end
        if (v.stall > 0) chk("stall_hold", 16'(bad_hold), 16'h0);
        recv("hi", v.hi, 1'b0, v.e);
        recv("lo", v.lo, 1'b1, v.e);
        chk("busy_after_tx", 16'(busy), 16'h0);
        chk("valid_after_tx", 16'(out_valid), 16'h0);
        chk("ula_sel_hold", 16'(ula_sel), 16'(v.sel[3:0]));
        chk("ula_a_hold", 16'(ula_a), 16'(v.a));
        chk("ula_b_hold", 16'(ula_b), 16'(v.b));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        vec_t rf;
`ifdef ULA_DIVZERO_CHK_EN
        vecs[2] = '{8'h03, 8'hFF, 8'h00, 0, 0, 8'hFF, 8'hFF, 1'b1};
`else
        vecs[2] = '{8'h03, 8'hFF, 8'h00, 0, 0, 8'hDE, 8'hAD, 1'b0};
`endif
        vecs[0] = '{8'h00, 8'h18, 8'h1F, 0, 0, 8'h00, 8'h37, 1'b0};
        vecs[1] = '{8'h02, 8'hFE, 8'hF5, 0, 5, 8'hF3, 8'h16, 1'b0};
        vecs[3] = '{8'h03, 8'hEA, 8'h09, 3, 0, 8'h00, 8'h1A, 1'b0};
        vecs[4] = '{8'h01, 8'hFF, 8'hF7, 0, 0, 8'h00, 8'h08, 1'b0};
        vecs[5] = '{8'hA0, 8'h80, 8'h80, 1, 2, 8'h01, 8'h00, 1'b0};
        rf      = '{8'h00, 8'h01, 8'h01, 0, 0, 8'h00, 8'h02, 1'b0};

        rst       = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 16'(in_ready), 16'h0);
        chk("rst_out_valid", 16'(out_valid), 16'h0);
        chk("rst_out_data", 16'(out_data), 16'h0);
        chk("rst_out_last", 16'(out_last), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_err", 16'(err), 16'h0);
        chk("rst_ula_a", 16'(ula_a), 16'h0);
        chk("rst_ula_b", 16'(ula_b), 16'h0);
        chk("rst_ula_sel", 16'(ula_sel), 16'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", 16'(in_ready), 16'h1);

        for (int i = 0; i < 6; i++) run_frame(vecs[i]);

        // Reset after the A byte: partial frame must vanish without a response
        send_byte(8'h02);
        send_byte(8'h55);
        chk("mid_busy_pre", 16'(busy), 16'h1);
        rst = 1'b1;
        #1;
        chk("mid_ula_a", 16'(ula_a), 16'h0);
        chk("mid_ula_sel", 16'(ula_sel), 16'h0);
        chk("mid_busy", 16'(busy), 16'h0);
        chk("mid_in_ready", 16'(in_ready), 16'h0);
        chk("mid_out_valid", 16'(out_valid), 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_no_response", 16'(out_valid), 16'h0);
        run_frame(rf);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ula_cmd_seq.md
# ula_cmd_seq

Byte-stream command sequencer that sits directly upstream and downstream of the ULA. It receives a 3-byte command frame (selector, A, B) and drives registered operands into the ULA. After a configurable settle time it captures the 16-bit result S and returns it as a 2-byte response frame. Both streams use valid/ready handshakes, which decouples the combinational ULA from the system bus.

## Interface
Parameters:
- EXEC_CYCLES, 1, number of cycles operands are held stable before S is captured (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  8  command byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  sequencer accepts a byte this cycle.
- out_data  out  8  response byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the byte this cycle.
- out_last  out  1  marks the final byte of the response frame.
- err  out  1  error flag for the current response; valid while out_valid=1.
- busy  out  1  a frame is in progress, i.e. the state is not RX_SEL.
- ula_a  out  8  operand A to the ULA.
- ula_b  out  8  operand B to the ULA.
- ula_sel  out  4  operation selector to the ULA.
- ula_s  in  16  ULA result.

## Operation
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Handshakes: a byte transfers on a rising edge with valid&&ready. Data is sampled only on transfer.
- State machine: RX_SEL → RX_A → RX_B → EXEC → CAP → TX_HI → TX_LO → RX_SEL.
- RX_SEL: in_ready=1. On transfer, ula_sel ← in_data[3:0] (bits 7:4 ignored) and err ← 0.
- RX_A: in_ready=1. On transfer, ula_a ← in_data.
- RX_B: in_ready=1. On transfer, ula_b ← in_data, exec counter ← EXEC_CYCLES−1.
- EXEC: in_ready=0. Counter decrements each cycle; exit to CAP when the counter is 0.
- CAP: res[15:0] ← ula_s; err updated per Configuration. Single cycle.
- TX_HI: out_valid=1, out_data=res[15:8], out_last=0. Advance on out_ready.
- TX_LO: out_valid=1, out_data=res[7:0], out_last=1. Advance to RX_SEL on out_ready.
- Operand hold: ula_a, ula_b and ula_sel hold their values until overwritten by the next frame. The ULA inputs never glitch during EXEC or CAP.
- Result width: res is 16 bits and carries ula_s unchanged. No truncation, sign extension or arithmetic inside this block.
- in_ready is 0 in all non-RX states, so bytes presented during EXEC, CAP or TX are stalled, never dropped.
- out_valid stays asserted and out_data stays stable until a transfer occurs, with no dependency on out_ready. Backpressure may last indefinitely.

## Timing
- Reset values: state=RX_SEL, ula_a=0, ula_b=0, ula_sel=0, res=0, err=0, out_valid=0, out_last=0, out_data=0, busy=0.
- in_ready is forced to 0 while rst is high and rises in the first cycle after deassertion.
- Latency: out_valid rises EXEC_CYCLES+1 cycles after the edge that accepts B.
- Minimum frame period: 3 + EXEC_CYCLES + 1 + 2 cycles with no stalls.
- Reset mid-frame: immediate return to reset values. A partial frame is discarded and no response is produced.
- busy is registered with the state and is 1 from the edge that accepts the selector until the edge that transfers the TX_LO byte.

## Configuration
- Macro: ULA_DIVZERO_CHK_EN.
- Defined: in CAP, if ula_sel==4'b0011 and ula_b==0, then res ← 16'hFFFF and err ← 1. Otherwise err ← 0.
- Undefined: res ← ula_s unconditionally and err is tied to 0.

## Test plan
- Add: frame {0x00, 0x18, 0x1F}, out_ready=1 → bytes 0x00, 0x37; out_last on the second byte; err=0.
- Multiply with backpressure: frame {0x02, 0xFE, 0xF5}, out_ready held 0 for 5 cycles → out_data stays 0xF3 with out_valid=1 throughout. Then 0xF3, 0x16 transfer.
- Divide by zero: frame {0x03, 0xFF, 0x00} → with ULA_DIVZERO_CHK_EN, response 0xFF, 0xFF with err=1. Without it, the response is raw ula_s and err=0.
- Divide with input gaps: frame {0x03, 0xEA, 0x09} with in_valid gaps of 3 cycles between bytes → response 0x00, 0x1A. in_ready=0 throughout EXEC, CAP and TX.
- Latency: EXEC_CYCLES=4, frame {0x01, 0xFF, 0xF7} → out_valid rises exactly 5 cycles after B is accepted; response 0x00, 0x08.
- Reset mid-frame: assert rst after the A byte is accepted → all outputs return to reset values at once. The next full frame {0x00, 0x01, 0x01} yields 0x00, 0x02.
